// File: rtl/coin_payer.sv
// coin_payer
// ----------
// Customer-side driver for the vending machine coin interface. A requested
// amount (in 10gr units) is paid as single-cycle coin pulses, choosing the
// coins greedily (50, 20, 10, 5, 2, 1). The block then waits for the drink
// pulse, totals the change pulses returned by the machine and reports the
// end of the transaction with a one-cycle done pulse.
//
// Parameters
//   COIN_GAP      idle cycles between consecutive coin pulses (0 = back-to-back)
//   DRINK_TIMEOUT cycles to wait for drink after the last coin before aborting
//   CHANGE_QUIET  consecutive cycles without change that end collection
//
// Ports
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   start, amount       transaction request; amount latched when start is accepted
//   busy                high from accepted start until the done cycle
//   done                one-cycle end-of-transaction pulse
//   timeout             valid with done: 1 = drink never arrived
//   paid_total          value inserted so far, held after done
//   change_total        change collected, held after done, saturates at 255
//   coin_1..coin_50     registered one-hot coin pulses towards the machine
//   drink               drink pulse from the machine
//   coin_1_o..coin_50_o change pulses from the machine (any combination per cycle)

module coin_payer #(
  parameter int COIN_GAP      = 1,
  parameter int DRINK_TIMEOUT = 64,
  parameter int CHANGE_QUIET  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] amount,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] paid_total,
  output logic [7:0] change_total,
  output logic       coin_1,
  output logic       coin_2,
  output logic       coin_5,
  output logic       coin_10,
  output logic       coin_20,
  output logic       coin_50,
  input  logic       drink,
  input  logic       coin_1_o,
  input  logic       coin_2_o,
  input  logic       coin_5_o,
  input  logic       coin_10_o,
  input  logic       coin_20_o,
  input  logic       coin_50_o
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PAY        = 3'd1;
  localparam logic [2:0] S_GAP        = 3'd2;
  localparam logic [2:0] S_WAIT_DRINK = 3'd3;
  localparam logic [2:0] S_COLLECT    = 3'd4;
  localparam logic [2:0] S_FINISH     = 3'd5;

  // One counter serves the gap, drink-wait and quiet phases since they never
  // overlap. 16 bits covers any practical parameter value.
  localparam int CNT_W = 16;

  logic [2:0]       state_q;
  logic [7:0]       remaining_q;
  logic [7:0]       paid_q;
  logic [7:0]       change_q;
  logic [5:0]       coin_q;        // bit order: 1, 2, 5, 10, 20, 50
  logic             busy_q;
  logic             done_q;
  logic             timeout_q;
  logic             drink_seen_q;  // drink arrived while still paying
  logic [CNT_W-1:0] cnt_q;

  logic [5:0]       sel_coin;
  logic [7:0]       sel_val;
  logic [5:0]       chg_vec;
  logic [8:0]       pulse_sum;
  logic [8:0]       change_sum;
  logic [7:0]       change_next;
  logic             change_active;

  // Greedy coin choice: largest coin not exceeding what is still owed.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    sel_coin = 6'b000000;
    sel_val  = 8'd0;
    if (remaining_q >= 8'd50) begin
      sel_coin = 6'b100000;
      sel_val  = 8'd50;
    end else if (remaining_q >= 8'd20) begin
      sel_coin = 6'b010000;
      sel_val  = 8'd20;
    end else if (remaining_q >= 8'd10) begin
      sel_coin = 6'b001000;
      sel_val  = 8'd10;
    end else if (remaining_q >= 8'd5) begin
      sel_coin = 6'b000100;
      sel_val  = 8'd5;
    end else if (remaining_q >= 8'd2) begin
      sel_coin = 6'b000010;
      sel_val  = 8'd2;
    end else if (remaining_q >= 8'd1) begin
      sel_coin = 6'b000001;
      sel_val  = 8'd1;
    end
  end

  // Change returned this cycle; several pulses at once all count.
  assign chg_vec       = {coin_50_o, coin_20_o, coin_10_o, coin_5_o, coin_2_o, coin_1_o};
  assign change_active = |chg_vec;

  always_comb begin
    pulse_sum = 9'd0;
    if (chg_vec[0]) pulse_sum = pulse_sum + 9'd1;
    if (chg_vec[1]) pulse_sum = pulse_sum + 9'd2;
    if (chg_vec[2]) pulse_sum = pulse_sum + 9'd5;
    if (chg_vec[3]) pulse_sum = pulse_sum + 9'd10;
    if (chg_vec[4]) pulse_sum = pulse_sum + 9'd20;
    if (chg_vec[5]) pulse_sum = pulse_sum + 9'd50;
  end

  // Running total plus at most 88 fits in 9 bits; clamp to 255.
  assign change_sum  = {1'b0, change_q} + pulse_sum;
  assign change_next = change_sum[8] ? 8'hFF : change_sum[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      remaining_q  <= 8'd0;
      paid_q       <= 8'd0;
      change_q     <= 8'd0;
      coin_q       <= 6'b000000;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      drink_seen_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      // Pulse outputs default low and are raised only where needed.
      coin_q <= 6'b000000;
      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            remaining_q  <= amount;
            paid_q       <= 8'd0;
            change_q     <= 8'd0;
            timeout_q    <= 1'b0;
            drink_seen_q <= 1'b0;
            busy_q       <= 1'b1;
            cnt_q        <= '0;
            state_q      <= (amount == 8'd0) ? S_WAIT_DRINK : S_PAY;
          end
        end

        S_PAY: begin
          coin_q      <= sel_coin;
          remaining_q <= remaining_q - sel_val;
          paid_q      <= paid_q + sel_val;
          cnt_q       <= '0;
          if (drink) drink_seen_q <= 1'b1;
          if (remaining_q == sel_val) begin
            // Last coin: an early drink skips the wait altogether.
            state_q <= (drink_seen_q || drink) ? S_COLLECT : S_WAIT_DRINK;
          end else if (COIN_GAP > 0) begin
            state_q <= S_GAP;
          end
        end

        S_GAP: begin
          if (drink) drink_seen_q <= 1'b1;
          if (cnt_q == CNT_W'(COIN_GAP - 1)) begin
            cnt_q   <= '0;
            state_q <= S_PAY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_WAIT_DRINK: begin
          // Change may arrive together with the drink pulse.
          if (change_active) change_q <= change_next;
          if (drink) begin
            cnt_q   <= '0;
            state_q <= S_COLLECT;
          end else if (cnt_q == CNT_W'(DRINK_TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_FINISH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_COLLECT: begin
          if (change_active) begin
            change_q <= change_next;
            cnt_q    <= '0;
          end else if (cnt_q == CNT_W'(CHANGE_QUIET - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // done is high during this cycle; totals stay until the next start.
        S_FINISH: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign paid_total   = paid_q;
  assign change_total = change_q;
  assign coin_1       = coin_q[0];
  assign coin_2       = coin_q[1];
  assign coin_5       = coin_q[2];
  assign coin_10      = coin_q[3];
  assign coin_20      = coin_q[4];
  assign coin_50      = coin_q[5];

endmodule
